// File: rtl/arbitro_divisor.sv
// Round-robin arbiter/sequencer sharing one divider among N_REQ requesters.
// Grants one request, drives the divider under a watchdog, returns a one-hot tagged result.
module arbitro_divisor #(
    parameter int N_REQ   = 4,
    parameter int LARGURA = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*LARGURA-1:0]   dividendo_in,
    input  logic [N_REQ*LARGURA-1:0]   divisor_in,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           valid_out,
    output logic [LARGURA-1:0]         quociente_out,
    output logic [LARGURA-1:0]         resto_out,
    output logic                       div_zero_out,
    output logic                       overflow_out,
    output logic                       timeout_out,
    output logic                       ocupado,
    output logic [LARGURA-1:0]         div_dividendo,
    output logic [LARGURA-1:0]         div_divisor,
    output logic                       div_start,
    output logic                       div_abort,
    input  logic [LARGURA-1:0]         div_quociente,
    input  logic [LARGURA-1:0]         div_resto,
    input  logic                       div_done,
    input  logic                       div_div_zero,
    input  logic                       div_overflow
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR = N_REQ;
    localparam logic [7:0] LIMITE = 8'(TIMEOUT);

    typedef enum logic [1:0] {OCIOSO, INICIA, AGUARDA, ENTREGA} estado_t;

    estado_t            estado;
    logic [IDX_W-1:0]   ult;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   vencedor;
    logic [IDX_W-1:0]   idx;
    logic               tem_req;
    logic [LARGURA-1:0] dividendo_q;
    logic [LARGURA-1:0] divisor_q;
    logic [7:0]         wd;
    logic [LARGURA-1:0] dvd_arr [N_REQ];
    logic [LARGURA-1:0] dvs_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign dvd_arr[g] = dividendo_in[g*LARGURA +: LARGURA];
        assign dvs_arr[g] = divisor_in[g*LARGURA +: LARGURA];
    end

    // Search starts one past the last grant; first asserted request wins.
    always_comb begin
        vencedor = ult;
        tem_req  = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NR; k++) begin
            idx = IDX_W'((32'(ult) + k) % NR);
            if (!tem_req && req[idx]) begin
                tem_req  = 1'b1;
                vencedor = idx;
            end
        end
    end

    assign ocupado       = (estado != OCIOSO);
    assign div_dividendo = dividendo_q;
    assign div_divisor   = divisor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado        <= OCIOSO;
            ult           <= IDX_W'(N_REQ - 1);
            sel           <= '0;
            dividendo_q   <= '0;
            divisor_q     <= '0;
            wd            <= '0;
            ack           <= '0;
            valid_out     <= '0;
            quociente_out <= '0;
            resto_out     <= '0;
            div_zero_out  <= 1'b0;
            overflow_out  <= 1'b0;
            timeout_out   <= 1'b0;
            div_start     <= 1'b0;
            div_abort     <= 1'b0;
        end else begin
            ack       <= '0;
            valid_out <= '0;
            div_start <= 1'b0;
            div_abort <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (tem_req) begin
                        sel           <= vencedor;
                        ult           <= vencedor;
                        dividendo_q   <= dvd_arr[vencedor];
                        divisor_q     <= dvs_arr[vencedor];
                        ack[vencedor] <= 1'b1;
                        div_start     <= (dvs_arr[vencedor] != '0);
                        estado        <= INICIA;
                    end
                end
                INICIA: begin
                    if (divisor_q == '0) begin
                        quociente_out  <= '1;
                        resto_out      <= dividendo_q;
                        div_zero_out   <= 1'b1;
                        overflow_out   <= 1'b0;
                        timeout_out    <= 1'b0;
                        valid_out[sel] <= 1'b1;
                        estado         <= ENTREGA;
                    end else begin
                        wd     <= '0;
                        estado <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    // done is checked first so it wins a tie with the watchdog
                    if (div_done) begin
                        quociente_out  <= div_quociente;
                        resto_out      <= div_resto;
                        div_zero_out   <= div_div_zero;
                        overflow_out   <= div_overflow;
                        timeout_out    <= 1'b0;
                        valid_out[sel] <= 1'b1;
                        estado         <= ENTREGA;
                    end else if (wd + 8'd1 == LIMITE) begin
                        quociente_out  <= '0;
                        resto_out      <= '0;
                        div_zero_out   <= 1'b0;
                        overflow_out   <= 1'b0;
                        timeout_out    <= 1'b1;
                        valid_out[sel] <= 1'b1;
                        div_abort      <= 1'b1;
                        estado         <= ENTREGA;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                ENTREGA: begin
                    estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: doc/arbitro_divisor.md
# arbitro_divisor

- Round-robin arbiter and sequencer that shares one `divisor_real` instance among `N_REQ` requesters.
- Grants one request at a time, latches its operands, and pulses the divider `start`. It then waits for `done` under a watchdog and returns the result on a shared result bus with a one-hot valid.
- Sits between the requesting datapath blocks (ULA control, software-visible ports) and the single divider, so a second divider is never needed.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `LARGURA`, 8, operand/result width; fixed to the divider width.
- `TIMEOUT`, 31, maximum cycles spent in `AGUARDA` before aborting (1..255).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N_REQ  level request per requester.
- `dividendo_in`  in  N_REQ*LARGURA  packed dividends; requester i uses bits [i*LARGURA +: LARGURA].
- `divisor_in`  in  N_REQ*LARGURA  packed divisors, same packing.
- `ack`  out  N_REQ  one-hot, one-cycle pulse; operands of requester i were captured.
- `valid_out`  out  N_REQ  one-hot, one-cycle pulse; the result bus belongs to requester i.
- `quociente_out`, `resto_out`  out  LARGURA  result bus; meaningful only while a `valid_out` bit is high.
- `div_zero_out`, `overflow_out`, `timeout_out`  out  1  status, qualified by `valid_out`.
- `ocupado`  out  1  high in any state other than `OCIOSO`.
- `div_dividendo`, `div_divisor`  out  LARGURA  divider operands.
  - Driven from the internal latches.
  - Stable from `INICIA` through `ENTREGA`.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_abort`  out  1  one-cycle pulse; integration ORs it into the divider `rst`.
- `div_quociente`, `div_resto`  in  LARGURA  divider results, valid while `div_done` is high.
- `div_done`, `div_div_zero`, `div_overflow`  in  1  divider outputs.
  - `div_done` is a one-cycle pulse, at least 1 cycle after `div_start`.

## Operation
- **States:** `OCIOSO`, `INICIA`, `AGUARDA`, `ENTREGA`.
- **Fairness:** round-robin pointer `ult` holds the last granted index.
  - The search starts at `ult+1` modulo `N_REQ`.
  - The first asserted `req` wins.
  - `ult` updates at each grant.
- **OCIOSO:** if any `req` bit is set, the winner index is latched into `sel`, its operands are latched, and the FSM goes to `INICIA`.
- **INICIA:** `ack[sel]`=1.
  - Latched divisor == 0: `div_start`=0. Results are forced to `div_zero_out`=1, `quociente_out`=all ones, `resto_out`=dividend, then go to `ENTREGA`.
  - Latched divisor != 0: `div_start`=1, watchdog cleared, go to `AGUARDA`.
- **AGUARDA:** the watchdog increments every cycle.
  - On `div_done`: capture `div_quociente`, `div_resto`, `div_div_zero`, `div_overflow`, set `timeout_out`=0, go to `ENTREGA`.
  - Watchdog reaches `TIMEOUT` without `div_done`: results=0, `timeout_out`=1, go to `ENTREGA`.
  - `div_done` in the same cycle the watchdog reaches `TIMEOUT`: `div_done` wins.
- **ENTREGA:** `valid_out[sel]`=1 with the captured results; `div_abort`=`timeout_out`; next state is `OCIOSO`.
- **Ignored inputs:** `div_done` outside `AGUARDA` is ignored. A stale `done` after an abort cannot leak, because `div_abort` resets the divider.
- **Requester contract:**
  - Hold `req` and operands stable until `ack`.
  - Deassert `req` the cycle after `ack`, or the request is arbitrated again as a new one.
  - Operand changes after `ack` have no effect.
  - Dropping `req` before `ack` withdraws the request.

## Timing
- **Reset:** state `OCIOSO`, `ult`=`N_REQ`-1 (so requester 0 wins first), `sel`=0.
  - All outputs 0: `ack`, `valid_out`, the result bus, all status flags, `ocupado`, `div_start`, `div_abort`, `div_dividendo`, `div_divisor`.
- **Reset mid-operation:** asynchronous return to the reset values. An in-flight result is discarded and no `valid_out` is issued.
- **Grant latency:** `req` sampled at edge 0 → `ack` and `div_start` high in cycle 1 → `AGUARDA` from cycle 2.
- **Normal latency:** divider latency D (cycles from `div_start` to `div_done`) → `valid_out` in cycle 2+D → `OCIOSO` in cycle 3+D. The next grant can fire at the edge ending cycle 3+D.
- **Divide-by-zero latency:** `ack` in cycle 1, `valid_out` in cycle 2.
- **Timeout latency:** `valid_out` with `timeout_out`=1 in cycle 2+`TIMEOUT`.
- **Throughput:** one operation per D+3 cycles.
- **Pulse widths:** all pulses are exactly one cycle. At most one bit each of `ack` and `valid_out` is ever high.

## Test plan
- **Single request:** bench divider model with D=8; `req[1]` with 200/7 → `ack[1]` in cycle 1, `div_start` in cycle 1, `valid_out[1]` in cycle 10 with quociente 28, resto 4, all flags 0.
- **Round robin:** `req`=4'b1111 held continuously → grants in order 0,1,2,3,0. `req` then drops to 4'b1010 after grant 0 → next grants 1,3.
- **Divide by zero:** requester 2 with 55/0 → `div_start` never asserted; `valid_out[2]` in cycle 2 with `div_zero_out`=1, quociente 8'hFF, resto 55.
- **Timeout:** divider model never asserts `div_done`, `TIMEOUT`=31 → `valid_out` with `timeout_out`=1 and zeros in cycle 33; `div_abort` high the same cycle.
- **Watchdog tie:** `div_done` arrives exactly on the watchdog's last cycle → normal result, `timeout_out`=0, `div_abort`=0.
- **Reset mid-operation:** `rst` asserted in `AGUARDA` → all outputs 0 immediately, no `valid_out`. After release, `req`=4'b1001 → requester 0 is granted first.
